// File: rtl/char_render_ctrl.sv
// char_render_ctrl: renders one scanline of text into the pixel buffer.
//
// Each character cell takes four reads: the character row buffer (code and
// attribute), font memory (8-bit pattern) and the palette twice (fg, bg).
// Every cell occupies one 8-cycle slot. The fetch for cell c+1 overlaps the
// eight pixel writes of cell c, so after a one-slot prologue the block writes
// one pixel every cycle until the line is complete.
//
// Ports:
//   clk, nrst            pixel clock, asynchronous active-low reset
//   start, font_line     launch pulse and scanline within the cell (sampled on start)
//   busy, done           line in progress / one-cycle pulse after the last write
//   chrowbuf_rd*         char row buffer read port (strobe active low)
//   fontmem_rd*          font memory read port (strobe active low)
//   palette_rd*          palette read port (strobe active low)
//   pixbuf_wr*           pixel buffer write port (strobe active low)
// Every read returns data in the cycle after its strobe is low.
module char_render_ctrl #(
  parameter int NCOLS       = 100,
  parameter int PIXBUF_BASE = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [3:0]  font_line,
  output logic        busy,
  output logic        done,
  output logic        chrowbuf_rd,
  output logic [7:0]  chrowbuf_rd_addr,
  input  logic [15:0] chrowbuf_rd_data,
  output logic        fontmem_rd,
  output logic [11:0] fontmem_rd_addr,
  input  logic [7:0]  fontmem_rd_data,
  output logic        palette_rd,
  output logic [7:0]  palette_rd_addr,
  input  logic [15:0] palette_rd_data,
  output logic        pixbuf_wr,
  output logic [9:0]  pixbuf_wr_addr,
  output logic [15:0] pixbuf_wr_data
);

  typedef enum logic [1:0] {IDLE, PROLOGUE, RENDER} state_t;

  localparam logic [7:0] LAST_COL = 8'(NCOLS - 1);
  localparam logic [9:0] BASE     = 10'(PIXBUF_BASE);

  state_t      st, st_n;
  logic [2:0]  ph, ph_n;     // phase within the current slot
  logic [7:0]  col, col_n;   // slot index (cell being written in RENDER)
  logic        done_n;
  logic [3:0]  fl;           // font_line latched at launch
  logic [3:0]  attr_bg;      // bg index held from p1 until its palette read at p3

  // "next" cell data being fetched, "current" cell data being written
  logic [7:0]  pat_nxt, pat_cur;
  logic [15:0] fg_nxt, bg_nxt, fg_cur, bg_cur;

  logic        fetch_en, fetch_en_n;
  logic [7:0]  fetch_col_n;
  logic [9:0]  wr_addr_n;
  logic [7:0]  pat_src;
  logic [15:0] fg_src, bg_src, pix_n;

  // Next-state logic; outputs below are registered from these next values so
  // that each strobe is low exactly in the cycle of its phase.
  always_comb begin
    st_n   = st;
    ph_n   = ph;
    col_n  = col;
    done_n = 1'b0;
    unique case (st)
      IDLE: begin
        // done is still high in the first IDLE cycle; a start there is too early
        if (start && !done) begin
          st_n  = PROLOGUE;
          ph_n  = 3'd0;
          col_n = 8'd0;
        end
      end
      PROLOGUE: begin
        ph_n = ph + 3'd1;
        if (ph == 3'd7) begin
          st_n  = RENDER;
          col_n = 8'd0;
        end
      end
      RENDER: begin
        ph_n = ph + 3'd1;
        if (ph == 3'd7) begin
          if (col == LAST_COL) begin
            st_n   = IDLE;
            done_n = 1'b1;
          end else begin
            col_n = col + 8'd1;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // The last RENDER slot has no following column to fetch.
  assign fetch_en    = (st == PROLOGUE) || ((st == RENDER) && (col != LAST_COL));
  assign fetch_en_n  = (st_n == PROLOGUE) || ((st_n == RENDER) && (col_n != LAST_COL));
  assign fetch_col_n = (st_n == PROLOGUE) ? 8'd0 : col_n + 8'd1;
  assign wr_addr_n   = BASE + 10'({col_n, ph_n});

  // Entering p0 the next-cell registers are being copied to current, so the
  // first pixel of a slot is taken straight from the next-cell registers.
  always_comb begin
    pat_src = (ph == 3'd7) ? pat_nxt : pat_cur;
    fg_src  = (ph == 3'd7) ? fg_nxt  : fg_cur;
    bg_src  = (ph == 3'd7) ? bg_nxt  : bg_cur;
    pix_n   = pat_src[3'd7 - ph_n] ? fg_src : bg_src;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st               <= IDLE;
      ph               <= 3'd0;
      col              <= 8'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      fl               <= 4'd0;
      attr_bg          <= 4'd0;
      pat_nxt          <= 8'd0;
      pat_cur          <= 8'd0;
      fg_nxt           <= 16'd0;
      bg_nxt           <= 16'd0;
      fg_cur           <= 16'd0;
      bg_cur           <= 16'd0;
      chrowbuf_rd      <= 1'b1;
      chrowbuf_rd_addr <= 8'd0;
      fontmem_rd       <= 1'b1;
      fontmem_rd_addr  <= 12'd0;
      palette_rd       <= 1'b1;
      palette_rd_addr  <= 8'd0;
      pixbuf_wr        <= 1'b1;
      pixbuf_wr_addr   <= 10'd0;
      pixbuf_wr_data   <= 16'd0;
    end else begin
      st   <= st_n;
      ph   <= ph_n;
      col  <= col_n;
      done <= done_n;
      busy <= (st_n != IDLE);

      if ((st == IDLE) && (st_n == PROLOGUE)) fl <= font_line;

      // p0: char row buffer read
      chrowbuf_rd <= !(fetch_en_n && (ph_n == 3'd0));
      if (fetch_en_n && (ph_n == 3'd0)) chrowbuf_rd_addr <= fetch_col_n;

      // p2: font read and fg palette read, addressed from the row data of p1
      fontmem_rd <= !(fetch_en_n && (ph_n == 3'd2));
      palette_rd <= !(fetch_en_n && ((ph_n == 3'd2) || (ph_n == 3'd3)));
      if (fetch_en_n && (ph_n == 3'd2)) begin
        fontmem_rd_addr <= {chrowbuf_rd_data[15:8], fl};
        palette_rd_addr <= {4'h0, chrowbuf_rd_data[3:0]};
        attr_bg         <= chrowbuf_rd_data[7:4];
      end
      // p3: bg palette read
      if (fetch_en_n && (ph_n == 3'd3)) palette_rd_addr <= {4'h0, attr_bg};

      if (fetch_en && (ph == 3'd3)) begin
        pat_nxt <= fontmem_rd_data;
        fg_nxt  <= palette_rd_data;
      end
      if (fetch_en && (ph == 3'd4)) bg_nxt <= palette_rd_data;

      if ((st != IDLE) && (ph == 3'd7)) begin
        pat_cur <= pat_nxt;
        fg_cur  <= fg_nxt;
        bg_cur  <= bg_nxt;
      end

      pixbuf_wr <= !(st_n == RENDER);
      if (st_n == RENDER) begin
        pixbuf_wr_addr <= wr_addr_n;
        pixbuf_wr_data <= pix_n;
      end
    end
  end

endmodule

// File: tb/tb_char_render_ctrl.sv
module tb_char_render_ctrl;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT 1: NCOLS=100, base 0
  logic        start, busy, done;
  logic [3:0]  font_line;
  logic        chrowbuf_rd, fontmem_rd, palette_rd, pixbuf_wr;
  logic [7:0]  chrowbuf_rd_addr, palette_rd_addr, fontmem_rd_data;
  logic [11:0] fontmem_rd_addr;
  logic [15:0] chrowbuf_rd_data, palette_rd_data, pixbuf_wr_data;
  logic [9:0]  pixbuf_wr_addr;

  // DUT 2: NCOLS=2, base 1016 (address wrap)
  logic        start2, busy2, done2;
  logic [3:0]  font_line2;
  logic        chrowbuf_rd2, fontmem_rd2, palette_rd2, pixbuf_wr2;
  logic [7:0]  chrowbuf_rd_addr2, palette_rd_addr2, fontmem_rd_data2;
  logic [11:0] fontmem_rd_addr2;
  logic [15:0] chrowbuf_rd_data2, palette_rd_data2, pixbuf_wr_data2;
  logic [9:0]  pixbuf_wr_addr2;

  char_render_ctrl #(.NCOLS(100), .PIXBUF_BASE(0)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .font_line(font_line),
    .busy(busy), .done(done),
    .chrowbuf_rd(chrowbuf_rd), .chrowbuf_rd_addr(chrowbuf_rd_addr), .chrowbuf_rd_data(chrowbuf_rd_data),
    .fontmem_rd(fontmem_rd), .fontmem_rd_addr(fontmem_rd_addr), .fontmem_rd_data(fontmem_rd_data),
    .palette_rd(palette_rd), .palette_rd_addr(palette_rd_addr), .palette_rd_data(palette_rd_data),
    .pixbuf_wr(pixbuf_wr), .pixbuf_wr_addr(pixbuf_wr_addr), .pixbuf_wr_data(pixbuf_wr_data)
  );

  char_render_ctrl #(.NCOLS(2), .PIXBUF_BASE(1016)) u_dut2 (
    .clk(clk), .nrst(nrst), .start(start2), .font_line(font_line2),
    .busy(busy2), .done(done2),
    .chrowbuf_rd(chrowbuf_rd2), .chrowbuf_rd_addr(chrowbuf_rd_addr2), .chrowbuf_rd_data(chrowbuf_rd_data2),
    .fontmem_rd(fontmem_rd2), .fontmem_rd_addr(fontmem_rd_addr2), .fontmem_rd_data(fontmem_rd_data2),
    .palette_rd(palette_rd2), .palette_rd_addr(palette_rd_addr2), .palette_rd_data(palette_rd_data2),
    .pixbuf_wr(pixbuf_wr2), .pixbuf_wr_addr(pixbuf_wr_addr2), .pixbuf_wr_data(pixbuf_wr_data2)
  );

  // Memories: data appears in the cycle after the strobe is low.
  logic [15:0] chrowbuf_m [256];
  logic [7:0]  fontmem_m  [4096];
  logic [15:0] palette_m  [256];

  always @(posedge clk) begin
    if (!chrowbuf_rd)  chrowbuf_rd_data  <= chrowbuf_m[chrowbuf_rd_addr];
    if (!fontmem_rd)   fontmem_rd_data   <= fontmem_m[fontmem_rd_addr];
    if (!palette_rd)   palette_rd_data   <= palette_m[palette_rd_addr];
    if (!chrowbuf_rd2) chrowbuf_rd_data2 <= chrowbuf_m[chrowbuf_rd_addr2];
    if (!fontmem_rd2)  fontmem_rd_data2  <= fontmem_m[fontmem_rd_addr2];
    if (!palette_rd2)  palette_rd_data2  <= palette_m[palette_rd_addr2];
  end

  // Monitors: log every access with the cycle it happened in.
  int          w_cyc[$], c_cyc[$], f_cyc[$], p_cyc[$], d_cyc[$], b_cyc[$], w2_cyc[$];
  logic [9:0]  w_addr[$], w2_addr[$];
  logic [15:0] w_data[$], w2_data[$];
  logic [7:0]  c_addr[$];
  logic [11:0] f_addr[$];

  always @(negedge clk) begin
    if (pixbuf_wr === 1'b0) begin
      w_cyc.push_back(cyc); w_addr.push_back(pixbuf_wr_addr); w_data.push_back(pixbuf_wr_data);
    end
    if (chrowbuf_rd === 1'b0) begin c_cyc.push_back(cyc); c_addr.push_back(chrowbuf_rd_addr); end
    if (fontmem_rd === 1'b0)  begin f_cyc.push_back(cyc); f_addr.push_back(fontmem_rd_addr); end
    if (palette_rd === 1'b0)  p_cyc.push_back(cyc);
    if (done === 1'b1)        d_cyc.push_back(cyc);
    if (busy === 1'b1)        b_cyc.push_back(cyc);
    if (pixbuf_wr2 === 1'b0) begin
      w2_cyc.push_back(cyc); w2_addr.push_back(pixbuf_wr_addr2); w2_data.push_back(pixbuf_wr_data2);
    end
  end

  int nasrt = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input int t);
    while (cyc < t) tick();
  endtask

  // Reference pixel: cell c, pixel p, straight from the memory contents.
  function automatic logic [15:0] ref_pix(input int c, input int p, input logic [3:0] fl);
    logic [15:0] ent;
    logic [7:0]  pat;
    ent = chrowbuf_m[c];
    pat = fontmem_m[{ent[15:8], fl}];
    return pat[3'(7 - p)] ? palette_m[{4'h0, ent[3:0]}] : palette_m[{4'h0, ent[7:4]}];
  endfunction

  // Check one full line of DUT 1 launched in cycle s (NCOLS=n, base 0).
  task automatic check_line(input int s, input int n, input logic [3:0] fl, input string tag);
    int lo, hi, nw, badw, nc, badc, nf, badf, np, nd, dc, nb, bfirst, blast;
    lo = s; hi = s + 8*n + 10;
    nw = 0; badw = 0; nc = 0; badc = 0; nf = 0; badf = 0; np = 0; nd = 0; dc = -1;
    nb = 0; bfirst = -1; blast = -1;
    foreach (w_cyc[i]) if (w_cyc[i] >= lo && w_cyc[i] <= hi) begin
      if (nw < 8*n) begin
        if (w_cyc[i] != s + 9 + nw || w_addr[i] != 10'(nw % 1024) ||
            w_data[i] != ref_pix(nw / 8, nw % 8, fl)) badw++;
      end
      nw++;
    end
    foreach (c_cyc[i]) if (c_cyc[i] >= lo && c_cyc[i] <= hi) begin
      if (c_cyc[i] != s + 1 + 8*nc || c_addr[i] != 8'(nc)) badc++;
      nc++;
    end
    foreach (f_cyc[i]) if (f_cyc[i] >= lo && f_cyc[i] <= hi) begin
      if (nf < n) begin
        if (f_cyc[i] != s + 3 + 8*nf || f_addr[i] != {chrowbuf_m[nf][15:8], fl}) badf++;
      end
      nf++;
    end
    foreach (p_cyc[i]) if (p_cyc[i] >= lo && p_cyc[i] <= hi) np++;
    foreach (d_cyc[i]) if (d_cyc[i] >= lo && d_cyc[i] <= hi) begin nd++; dc = d_cyc[i]; end
    foreach (b_cyc[i]) if (b_cyc[i] >= lo && b_cyc[i] <= hi) begin
      if (bfirst < 0) bfirst = b_cyc[i];
      blast = b_cyc[i];
      nb++;
    end
    chk({tag, "/wr_count"},    32'(nw),     32'(8*n));
    chk({tag, "/wr_bad"},      32'(badw),   32'd0);
    chk({tag, "/chrow_count"}, 32'(nc),     32'(n));
    chk({tag, "/chrow_bad"},   32'(badc),   32'd0);
    chk({tag, "/font_count"},  32'(nf),     32'(n));
    chk({tag, "/font_bad"},    32'(badf),   32'd0);
    chk({tag, "/pal_count"},   32'(np),     32'(2*n));
    chk({tag, "/done_count"},  32'(nd),     32'd1);
    chk({tag, "/done_cycle"},  32'(dc),     32'(s + 9 + 8*n));
    chk({tag, "/busy_count"},  32'(nb),     32'(8*n + 8));
    chk({tag, "/busy_first"},  32'(bfirst), 32'(s + 1));
    chk({tag, "/busy_last"},   32'(blast),  32'(s + 8 + 8*n));
  endtask

  logic [15:0] exp_px [8] = '{16'h0FF0, 16'h0006, 16'h0FF0, 16'h0006,
                              16'h0006, 16'h0FF0, 16'h0006, 16'h0FF0};

  initial begin
    int sA, sB, sC, sD, s2, nstray;
    logic [3:0] flc, fld, fl2;

    foreach (chrowbuf_m[i]) chrowbuf_m[i] = 16'($urandom);
    foreach (fontmem_m[i])  fontmem_m[i]  = 8'($urandom);
    foreach (palette_m[i])  palette_m[i]  = 16'($urandom) & 16'h0FFF;
    chrowbuf_m[0]    = 16'h411E;
    fontmem_m[12'h413] = 8'hA5;
    palette_m[8'h0E] = 16'h0FF0;
    palette_m[8'h01] = 16'h0006;

    nrst = 1'b1; start = 1'b0; font_line = 4'd0; start2 = 1'b0; font_line2 = 4'd0;
    #3 nrst = 1'b0;
    #1;
    chk("rst/strobes", 32'({chrowbuf_rd, fontmem_rd, palette_rd, pixbuf_wr}), 32'hF);
    chk("rst/busy_done", 32'({busy, done}), 32'd0);
    chk("rst/addrs", 32'({chrowbuf_rd_addr, fontmem_rd_addr, pixbuf_wr_addr}), 32'd0);
    chk("rst/wdata", 32'(pixbuf_wr_data), 32'd0);
    repeat (3) tick();
    nrst = 1'b1;
    repeat (2) tick();

    // Line A, with stray starts mid-line and in the done cycle; line B at +811
    sA = cyc; font_line = 4'd3; start = 1'b1; tick(); start = 1'b0;
    go(sA + 400); start = 1'b1; tick(); start = 1'b0;
    go(sA + 809); start = 1'b1;
    chk("A/done_at_809", 32'(done), 32'd1);
    tick(); start = 1'b0;
    go(sA + 811); sB = cyc; start = 1'b1; tick(); start = 1'b0;
    go(sB + 812);

    check_line(sA, 100, 4'd3, "A");
    chk("A/font_413", 32'(f_addr.size() > 0 ? f_addr[0] : 12'h0), 32'h413);
    for (int k = 0; k < 8; k++) chk($sformatf("A/px%0d", k),
        32'(w_data.size() > k ? w_data[k] : 16'hDEAD), 32'(exp_px[k]));
    check_line(sB, 100, 4'd3, "B");
    chk("B/first_write", 32'(w_cyc.size() > 800 ? w_cyc[800] : 0), 32'(sA + 820));
    chk("AB/total_writes", 32'(w_cyc.size()), 32'd1600);

    // Line C aborted by reset at cycle 300, then line D from scratch
    flc = 4'($urandom_range(0, 15));
    fld = 4'($urandom_range(0, 15));
    sC = cyc; font_line = flc; start = 1'b1; tick(); start = 1'b0;
    go(sC + 300);
    nrst = 1'b0;
    #1;
    chk("abort/strobes", 32'({chrowbuf_rd, fontmem_rd, palette_rd, pixbuf_wr}), 32'hF);
    chk("abort/busy_done", 32'({busy, done}), 32'd0);
    repeat (3) tick();
    nrst = 1'b1;
    repeat (20) tick();
    sD = cyc;
    nstray = 0;
    foreach (w_cyc[i]) if (w_cyc[i] >= sC + 300 && w_cyc[i] <= sD) nstray++;
    chk("abort/no_writes", 32'(nstray), 32'd0);
    chk("abort/idle_busy", 32'(busy), 32'd0);
    font_line = fld; start = 1'b1; tick(); start = 1'b0;
    go(sD + 812);
    check_line(sD, 100, fld, "D");

    // Address wrap on the 2-column instance
    fl2 = 4'($urandom_range(0, 15));
    s2 = cyc; font_line2 = fl2; start2 = 1'b1; tick(); start2 = 1'b0;
    go(s2 + 30);
    chk("wrap/count", 32'(w2_cyc.size()), 32'd16);
    for (int k = 0; k < 16 && k < w2_cyc.size(); k++) begin
      chk($sformatf("wrap/addr%0d", k), 32'(w2_addr[k]), 32'((1016 + k) % 1024));
      chk($sformatf("wrap/data%0d", k), 32'(w2_data[k]), 32'(ref_pix(k / 8, k % 8, fl2)));
      chk($sformatf("wrap/cyc%0d", k),  32'(w2_cyc[k]),  32'(s2 + 9 + k));
    end
    chk("wrap/done", 32'(done2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
